// File: rtl/uart_tx_core.sv
// uart_tx_core: serial transmit half of the UART.
// Sends start bit, DATA_WIDTH data bits (LSB first), optional parity and one
// stop bit. Each bit lasts Prescale clock cycles (0 behaves as 1). A new word
// accepted on the last stop cycle follows with no idle gap.
module uart_tx_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state, state_nx;
    logic [PRESCALE_WIDTH-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0]          idx, idx_nx;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic [PRESCALE_WIDTH-1:0] cnt_last;
    logic                      bit_end;
    logic                      load;
    logic                      tx_nx;
    logic                      busy_nx;

    // Parity over the latched word: even = XOR of data, odd = its inverse.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic odd);
        calc_parity = (^d) ^ odd;
    endfunction

    // Last count of a bit period; a latched prescale of 0 acts as 1.
    assign cnt_last = (presc_q == '0) ? '0 : presc_q - PRESCALE_WIDTH'(1);
    assign bit_end  = (cnt == cnt_last);

    // Next-state, counter/index and next line level; outputs are registered
    // from the next state so an accept drives the start bit from that edge.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        load     = 1'b0;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;

        if (state == IDLE) begin
            if (Data_Valid) begin
                load     = 1'b1;
                state_nx = START;
                cnt_nx   = '0;
                idx_nx   = '0;
            end
        end else if (!bit_end) begin
            cnt_nx = cnt + PRESCALE_WIDTH'(1);
        end else begin
            cnt_nx = '0;
            case (state)
                START: begin
                    state_nx = DATA;
                    idx_nx   = '0;
                end
                DATA: begin
                    if (idx == IDX_LAST) begin
                        state_nx = par_en_q ? PARITY : STOP;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
                PARITY: state_nx = STOP;
                STOP: begin
                    if (Data_Valid) begin
                        load     = 1'b1;
                        state_nx = START;
                        idx_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = data_q[idx_nx];
            PARITY:  tx_nx = calc_parity(data_q, par_typ_q);
            default: tx_nx = 1'b1;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State, bit-period counter, bit index and registered line outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            TX_OUT <= tx_nx;
            Busy   <= busy_nx;
        end
    end

    // Holding registers capture the word and frame settings on accept only.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= '0;
        end else if (load) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            presc_q   <= Prescale;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frame shapes, parity, back-to-back,
// ignored mid-frame requests, mid-frame reset and minimum prescale.
module tb_uart_tx_core;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    uart_tx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Stimulus only: one-cycle accept strobe, then scramble inputs so that
    // any sampling outside the accept edge would corrupt the frame.
    task automatic start_frame(input logic [7:0] d, input logic pen,
                               input logic ptyp, input logic [5:0] presc);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = presc;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA = ~d; PAR_EN = ~pen; PAR_TYP = ~ptyp; Prescale = presc + 6'd3;
    endtask

    task automatic test_reset();
        RST = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd0;
        repeat (3) @(negedge CLK);
        total++; if (TX_OUT !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", TX_OUT); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        // Reset must win over a simultaneous request.
        Data_Valid = 1'b1; P_DATA = 8'h00;
        @(negedge CLK);
        total++; if (TX_OUT !== 1'b1) begin bad++; $display("FAIL reset_prio_tx got=%b exp=1", TX_OUT); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_prio_busy got=%b exp=0", Busy); end
        Data_Valid = 1'b0; RST = 1'b1;
        @(negedge CLK);
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_no_parity();
        logic [0:9] pat;
        pat = 10'b0101001011;  // 0xA5: start, 1,0,1,0,0,1,0,1, stop
        start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
        for (int i = 0; i < 80; i++) begin
            total++; if (TX_OUT !== pat[i/8]) begin bad++; $display("FAIL np_tx cyc=%0d got=%b exp=%b", i, TX_OUT, pat[i/8]); end
            total++; if (Busy !== 1'b1) begin bad++; $display("FAIL np_busy cyc=%0d got=%b exp=1", i, Busy); end
            @(negedge CLK);
        end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL np_busy_end got=%b exp=0", Busy); end
        total++; if (TX_OUT !== 1'b1) begin bad++; $display("FAIL np_tx_end got=%b exp=1", TX_OUT); end
    endtask

    task automatic test_parity();
        logic [0:10] pat;
        for (int t = 0; t < 2; t++) begin
            // 0xA5 has four ones: even parity 0, odd parity 1.
            pat = (t == 0) ? 11'b01010010101 : 11'b01010010111;
            start_frame(8'hA5, 1'b1, t[0], 6'd4);
            for (int i = 0; i < 44; i++) begin
                total++; if (TX_OUT !== pat[i/4]) begin bad++; $display("FAIL par%0d_tx cyc=%0d got=%b exp=%b", t, i, TX_OUT, pat[i/4]); end
                total++; if (Busy !== 1'b1) begin bad++; $display("FAIL par%0d_busy cyc=%0d got=%b exp=1", t, i, Busy); end
                @(negedge CLK);
            end
            total++; if (Busy !== 1'b0) begin bad++; $display("FAIL par%0d_busy_end got=%b exp=0", t, Busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:19] pat;
        pat = 20'b0111100001_0000011111;  // 0x0F frame then 0xF0 frame
        start_frame(8'h0F, 1'b0, 1'b0, 6'd4);
        for (int i = 0; i < 80; i++) begin
            total++; if (TX_OUT !== pat[i/4]) begin bad++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", i, TX_OUT, pat[i/4]); end
            total++; if (Busy !== 1'b1) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=1", i, Busy); end
            if (i == 39) begin
                P_DATA = 8'hF0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4;
                Data_Valid = 1'b1;
            end
            if (i == 40) begin
                Data_Valid = 1'b0; P_DATA = 8'h00; Prescale = 6'd9;
            end
            @(negedge CLK);
        end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b exp=0", Busy); end
    endtask

    task automatic test_ignored();
        logic [0:9] pat;
        pat = 10'b0000000001;  // 0x00 frame
        start_frame(8'h00, 1'b0, 1'b0, 6'd2);
        for (int i = 0; i < 20; i++) begin
            total++; if (TX_OUT !== pat[i/2]) begin bad++; $display("FAIL ign_tx cyc=%0d got=%b exp=%b", i, TX_OUT, pat[i/2]); end
            if (i == 5) begin
                P_DATA = 8'hFF; PAR_EN = 1'b1; Prescale = 6'd1; Data_Valid = 1'b1;
            end
            if (i == 6) Data_Valid = 1'b0;
            @(negedge CLK);
        end
        for (int j = 0; j < 4; j++) begin
            total++; if (Busy !== 1'b0) begin bad++; $display("FAIL ign_busy_after cyc=%0d got=%b exp=0", j, Busy); end
            total++; if (TX_OUT !== 1'b1) begin bad++; $display("FAIL ign_tx_after cyc=%0d got=%b exp=1", j, TX_OUT); end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid();
        logic [0:9] pat;
        pat = 10'b0101010101;  // 0x55 frame, data bit 3 spans cycles 16..19
        start_frame(8'h55, 1'b0, 1'b0, 6'd4);
        for (int i = 0; i < 18; i++) begin
            total++; if (TX_OUT !== pat[i/4]) begin bad++; $display("FAIL rst_pre_tx cyc=%0d got=%b exp=%b", i, TX_OUT, pat[i/4]); end
            if (i == 17) RST = 1'b0;
            @(negedge CLK);
        end
        total++; if (TX_OUT !== 1'b1) begin bad++; $display("FAIL rst_mid_tx got=%b exp=1", TX_OUT); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", Busy); end
        RST = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge CLK);
            total++; if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin bad++; $display("FAIL rst_idle cyc=%0d got=%b%b exp=01", j, Busy, TX_OUT); end
        end
        pat = 10'b0001111001;  // 0x3C frame
        start_frame(8'h3C, 1'b0, 1'b0, 6'd4);
        for (int i = 0; i < 40; i++) begin
            total++; if (TX_OUT !== pat[i/4]) begin bad++; $display("FAIL rst_post_tx cyc=%0d got=%b exp=%b", i, TX_OUT, pat[i/4]); end
            total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rst_post_busy cyc=%0d got=%b exp=1", i, Busy); end
            @(negedge CLK);
        end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_post_busy_end got=%b exp=0", Busy); end
    endtask

    task automatic test_min_prescale();
        logic [0:9] pat;
        pat = 10'b0001111001;  // 0x3C frame, one cycle per bit
        for (int p = 0; p < 2; p++) begin
            start_frame(8'h3C, 1'b0, 1'b0, 6'(p));
            for (int i = 0; i < 10; i++) begin
                total++; if (TX_OUT !== pat[i]) begin bad++; $display("FAIL p%0d_tx cyc=%0d got=%b exp=%b", p, i, TX_OUT, pat[i]); end
                total++; if (Busy !== 1'b1) begin bad++; $display("FAIL p%0d_busy cyc=%0d got=%b exp=1", p, i, Busy); end
                @(negedge CLK);
            end
            total++; if (Busy !== 1'b0) begin bad++; $display("FAIL p%0d_busy_end got=%b exp=0", p, Busy); end
            total++; if (TX_OUT !== 1'b1) begin bad++; $display("FAIL p%0d_tx_end got=%b exp=1", p, TX_OUT); end
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_min_prescale();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Serial transmit half of the UART: accepts a parallel word with a one-cycle valid strobe and emits a start bit, data (LSB first), an optional parity bit and one stop bit on TX_OUT. Each bit lasts Prescale clock cycles, so the block runs on the same oversampled clock as the receive path and is configured by the same Prescale register value. It sits between the system register/FIFO side and the TX pad. Busy tells the upstream source when a new word can be accepted.

## Interface
- DATA_WIDTH, 8: data bits per frame.
- PRESCALE_WIDTH, 6: width of Prescale and of the internal bit-period counter.

- CLK  input  1  system clock. All state changes on rising edge.
- RST  input  1  reset: synchronous, active-low.
- P_DATA  input  DATA_WIDTH  word to send; sampled only on the accept cycle.
- Data_Valid  input  1  one-cycle request strobe.
- PAR_EN  input  1  1 = parity bit included; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- Prescale  input  PRESCALE_WIDTH  clock cycles per bit; sampled on accept.
- TX_OUT  output  1  serial line, idles high. Registered.
- Busy  output  1  frame in progress. Registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: state IDLE and Data_Valid = 1 at a rising edge. On that edge, latch P_DATA, PAR_EN, PAR_TYP and Prescale into holding registers. Go to START, clear the bit-period counter and bit index.
- Latched Prescale 0 is treated as 1.
- Parity is computed from the latched data: even = XOR of all data bits; odd = inverted XOR.
- Bit-period counter counts 0..P-1, where P is the effective latched prescale.
  - The state or bit advances on the edge where the counter equals P-1. The counter then wraps to 0.
- START drives 0.
- DATA drives latched_data[idx], for idx = 0..DATA_WIDTH-1. The index increments at each bit boundary. After the last data bit, go to PARITY if the latched PAR_EN = 1, else STOP.
- PARITY drives the parity bit, then goes to STOP.
- STOP drives 1. At the end of the stop bit:
  - If Data_Valid = 1 on that same edge, accept a new word and go directly to START. The line has no idle gap and Busy stays 1.
  - Otherwise go to IDLE.
- Data_Valid in any non-IDLE state other than the final STOP cycle is ignored. The word is dropped with no error flag. Input changes mid-frame have no effect.
- Busy = 1 in START, DATA, PARITY and STOP. Busy = 0 in IDLE.

## Timing
- Reset (RST = 0 at an edge) forces, after that edge: state IDLE, TX_OUT = 1, Busy = 0, counters and index 0, holding registers 0.
  - Reset mid-frame aborts the frame. The line is high from the next edge with no partial stop bit.
  - Reset has priority over Data_Valid on the same edge.
- Accept at edge k: from edge k, TX_OUT = 0 and Busy = 1. There is no combinational path from Data_Valid to TX_OUT.
- Each bit level holds for exactly P cycles.
- Frame length is (2 + DATA_WIDTH + PAR_EN) × P cycles. Busy falls on edge k + frame length when no back-to-back request arrives.
- Earliest next accept from IDLE is the edge after Busy falls.
- Back-to-back: new start bit begins exactly P cycles after the stop bit began.
- Prescale changes during a frame do not affect the frame; they apply from the next accept.
- Counter width is PRESCALE_WIDTH; P-1 always fits, so no overflow.

## Test plan
- 0xA5, PAR_EN = 0, Prescale = 8 → TX_OUT over 80 cycles, 8 cycles per bit: 0,1,0,1,0,0,1,0,1,1. Busy high for exactly 80 cycles, then 0.
- 0xA5, PAR_EN = 1, PAR_TYP = 0, Prescale = 4 → parity bit 0, frame 44 cycles. Repeat with PAR_TYP = 1 → parity bit 1.
- Two words 0x0F then 0xF0, second Data_Valid on the final stop cycle, Prescale = 4 → 80 contiguous cycles: Busy never drops and no idle-high gap between frames.
- Data_Valid pulsed with P_DATA = 0xFF during a 0x00 frame → frame still sends 0x00 and the 0xFF word never appears.
- RST low for one edge during data bit 3 → TX_OUT = 1 and Busy = 0 the next cycle. Idle until the next Data_Valid, then a correct full frame follows.
- Prescale = 0 and Prescale = 1, 0x3C, no parity → each bit 1 cycle, frame 10 cycles: 0,0,0,1,1,1,1,0,0,1.
